// File: rtl/v_seq_dispatch_if.sv
// Handshake and status bundle between the dispatch table and its environment.
// master drives instructions and completion events; slave is the dispatch table.
interface v_seq_dispatch_if #(
    parameter int OP_BITS  = 6,
    parameter int TAG_BITS = 3
);
    logic                in_valid;
    logic [OP_BITS-1:0]  in_op;
    logic                in_ready;

    logic                iss_valid;
    logic [OP_BITS-1:0]  iss_op;
    logic [TAG_BITS-1:0] iss_tag;
    logic                iss_ready;

    logic                rd_done;
    logic [TAG_BITS-1:0] rd_tag;
    logic                ex_done;
    logic [TAG_BITS-1:0] ex_tag;
    logic                wb_done;
    logic [TAG_BITS-1:0] wb_tag;

    logic                ret_valid;
    logic [OP_BITS-1:0]  ret_op;
    logic [TAG_BITS-1:0] ret_tag;

    logic [TAG_BITS:0]   count;
    logic                empty;
    logic                full;
    logic                err;

    modport master (
        output in_valid, in_op, iss_ready,
        output rd_done, rd_tag, ex_done, ex_tag, wb_done, wb_tag,
        input  in_ready, iss_valid, iss_op, iss_tag,
        input  ret_valid, ret_op, ret_tag, count, empty, full, err
    );

    modport slave (
        input  in_valid, in_op, iss_ready,
        input  rd_done, rd_tag, ex_done, ex_tag, wb_done, wb_tag,
        output in_ready, iss_valid, iss_op, iss_tag,
        output ret_valid, ret_op, ret_tag, count, empty, full, err
    );
endinterface

// File: rtl/v_seq_dispatch.sv
// In-order issue / out-of-order completion / in-order retire instruction table.
// Each slot tracks one instruction through IS -> RO -> EX -> WB -> DN -> FREE.
module v_seq_dispatch #(
    parameter int OP_BITS     = 6,
    parameter int NO_OF_SLOTS = 8,
    parameter int TAG_BITS    = 3
) (
    input  logic            clk,
    input  logic            nrst,
    v_seq_dispatch_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IS   = 3'b000,
        ST_RO   = 3'b001,
        ST_EX   = 3'b010,
        ST_WB   = 3'b011,
        ST_DN   = 3'b100,
        ST_FREE = 3'b111
    } stage_e;

    localparam logic [TAG_BITS:0]   FULL_CNT = (TAG_BITS+1)'(NO_OF_SLOTS);
    localparam logic [TAG_BITS:0]   CNT_ONE  = (TAG_BITS+1)'(1);
    localparam logic [TAG_BITS-1:0] TAG_ONE  = TAG_BITS'(1);

    stage_e              stage_q [NO_OF_SLOTS];
    logic [OP_BITS-1:0]  op_q    [NO_OF_SLOTS];
    logic [TAG_BITS-1:0] head_q;
    logic [TAG_BITS-1:0] iss_q;
    logic [TAG_BITS-1:0] tail_q;
    logic [TAG_BITS:0]   count_q;
    logic                err_q;
    logic                ret_valid_q;
    logic [OP_BITS-1:0]  ret_op_q;
    logic [TAG_BITS-1:0] ret_tag_q;

    logic is_full;
    logic push;
    logic issue;
    logic retire;
    logic rd_ok;
    logic ex_ok;
    logic wb_ok;
    logic proto_err;

    // All decisions look at the table as it stood before the edge, so push, issue,
    // retire and the three done events can act together on distinct slots.
    always_comb begin
        is_full   = (count_q == FULL_CNT);
        push      = bus.in_valid && !is_full;
        issue     = bus.iss_ready && (stage_q[iss_q] == ST_IS);
        retire    = (stage_q[head_q] == ST_DN);
        rd_ok     = (stage_q[bus.rd_tag] == ST_RO);
        ex_ok     = (stage_q[bus.ex_tag] == ST_EX);
        wb_ok     = (stage_q[bus.wb_tag] == ST_WB);
        proto_err = (bus.rd_done && !rd_ok) ||
                    (bus.ex_done && !ex_ok) ||
                    (bus.wb_done && !wb_ok);
    end

    // Slot stages, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (nrst) begin
            for (int i = 0; i < NO_OF_SLOTS; i++) begin
                stage_q[i] <= ST_FREE;
            end
            head_q  <= '0;
            iss_q   <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                stage_q[tail_q] <= ST_IS;
                tail_q          <= tail_q + TAG_ONE;
            end
            if (issue) begin
                stage_q[iss_q] <= ST_RO;
                iss_q          <= iss_q + TAG_ONE;
            end
            if (bus.rd_done && rd_ok) begin
                stage_q[bus.rd_tag] <= ST_EX;
            end
            if (bus.ex_done && ex_ok) begin
                stage_q[bus.ex_tag] <= ST_WB;
            end
            if (bus.wb_done && wb_ok) begin
                stage_q[bus.wb_tag] <= ST_DN;
            end
            if (retire) begin
                stage_q[head_q] <= ST_FREE;
                head_q          <= head_q + TAG_ONE;
            end
            case ({push, retire})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (proto_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Opcode storage needs no reset; a slot's opcode is only read while it is live.
    always_ff @(posedge clk) begin
        if (!nrst && push) begin
            op_q[tail_q] <= bus.in_op;
        end
    end

    // Retire pulse is registered so it appears in the cycle after the head frees.
    always_ff @(posedge clk) begin
        if (nrst) begin
            ret_valid_q <= 1'b0;
            ret_op_q    <= '0;
            ret_tag_q   <= '0;
        end else begin
            ret_valid_q <= retire;
            ret_op_q    <= op_q[head_q];
            ret_tag_q   <= head_q;
        end
    end

    assign bus.in_ready  = !is_full;
    assign bus.iss_valid = (stage_q[iss_q] == ST_IS);
    assign bus.iss_op    = op_q[iss_q];
    assign bus.iss_tag   = iss_q;
    assign bus.ret_valid = ret_valid_q;
    assign bus.ret_op    = ret_op_q;
    assign bus.ret_tag   = ret_tag_q;
    assign bus.count     = count_q;
    assign bus.empty     = (count_q == '0);
    assign bus.full      = is_full;
    assign bus.err       = err_q;

endmodule

// File: doc/v_seq_dispatch.md
V_SEQ_DISPATCH -- requirements
Module: v_seq_dispatch

Interface
REQ-001 The block SHALL have parameter OP_BITS, default 6, meaning opcode field width per entry.
REQ-002 The block SHALL have parameter NO_OF_SLOTS, default 8, meaning table depth; it is a power of 2.
REQ-003 The block SHALL have parameter TAG_BITS, default 3, meaning log2(NO_OF_SLOTS); tag equals slot index.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port nrst, input, 1 bit: synchronous, active-high reset (1 = reset, sampled on clk rising edge).
REQ-006 Port in_valid / in_op / in_ready: input 1 / input OP_BITS / output 1; instruction push handshake.
REQ-007 Port iss_valid / iss_op / iss_tag / iss_ready: output 1 / output OP_BITS / output TAG_BITS / input 1; dispatch handshake to functional units.
REQ-008 Port rd_done / rd_tag: input 1 / input TAG_BITS; operand read complete for tag.
REQ-009 Port ex_done / ex_tag: input 1 / input TAG_BITS; execution complete for tag.
REQ-010 Port wb_done / wb_tag: input 1 / input TAG_BITS; writeback complete for tag.
REQ-011 Port ret_valid / ret_op / ret_tag: output 1 / output OP_BITS / output TAG_BITS; one-cycle retire pulse.
REQ-012 Port count, output, TAG_BITS+1 bits: occupied slots, 0..NO_OF_SLOTS.
REQ-013 Port empty / full / err: outputs, 1 bit each; count==0 / count==NO_OF_SLOTS / sticky protocol error.

Function
REQ-014 Each slot SHALL hold {op[OP_BITS-1:0], stage[2:0]}; stage encoding IS=000 (queued), RO=001, EX=010, WB=011, DN=100, FREE=111.
REQ-015 Head, issue and tail pointers SHALL be TAG_BITS wide and wrap from NO_OF_SLOTS-1 to 0.
REQ-016 in_ready SHALL equal !full (combinational); retire in the same cycle does not make a full table accept.
REQ-017 Push (in_valid & in_ready) SHALL write {in_op, IS} to slot tail and advance tail at that edge.
REQ-018 iss_valid SHALL be 1 exactly when slot at issue pointer has stage IS; iss_op/iss_tag SHALL reflect that slot; an entry pushed at edge N is first offered in the cycle after edge N.
REQ-019 Issue handshake (iss_valid & iss_ready) SHALL set that slot RO and advance issue pointer; at most one issue per cycle, in program order.
REQ-020 rd_done SHALL move slot rd_tag RO->EX; ex_done SHALL move EX->WB; wb_done SHALL move WB->DN; all three may fire in one cycle on different tags.
REQ-021 A done event whose tag is not in the matching stage SHALL leave state unchanged and set err; err stays 1 until reset.
REQ-022 When head slot is DN at an edge, the slot SHALL become FREE, head advance, and in the following cycle ret_valid=1 with ret_op/ret_tag of that entry; otherwise ret_valid=0; max one retire per cycle.
REQ-023 count SHALL increment on push, decrement on retire, and be unchanged when both occur in the same edge.
REQ-024 Completion out of order SHALL be permitted; retirement SHALL be strictly in order (younger DN entries wait for head).
REQ-025 Push and issue of a different slot, and done events, SHALL all be honoured in the same cycle.

Reset
REQ-026 With nrst=1 at an edge, all slots SHALL become FREE, all pointers 0, count=0, empty=1, full=0, err=0, ret_valid=0, iss_valid=0; in-flight instructions are discarded.
REQ-027 Handshake inputs in a reset cycle SHALL be ignored; iss_op/ret_op/ret_tag values are don't-care while their valid is 0.

Verification
REQ-028 Reset then push op 6'h05 with iss_ready=1 -> next cycle iss_valid=1, iss_tag=0, iss_op=05; count=1.
REQ-029 Push 8 ops back-to-back with iss_ready=0 -> full=1, in_ready=0, count=8; ninth push ignored, count stays 8.
REQ-030 Issue tags 0,1; wb chain complete tag 1 before tag 0 -> no retire until tag 0 reaches DN, then ret_tag=0 followed next cycle by ret_tag=1.
REQ-031 Full table, head DN, push asserted same cycle -> push rejected, retire occurs, count=7, next cycle in_ready=1.
REQ-032 ex_done for a tag in RO -> err=1, slot stage unchanged; err persists until nrst=1.
REQ-033 Fill, retire, refill 12 instructions -> tags wrap 7->0, ret_op order equals push order, nrst mid-stream -> count=0, iss_valid=0 next cycle.
